// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional feature macro: DMEM_ARB_ROUND_ROBIN_EN (see dmem_arb_select).
`timescale 1ns/1ps
package dmem_arb_pkg;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    // sign_mask encoding: size one-hot in [2:0], sign-extend request in bit 3
    localparam int         SM_SIGNED_BIT = 3;
    localparam logic [3:0] SM_BYTE       = 4'b0001;
    localparam logic [3:0] SM_HALF       = 4'b0010;
    localparam logic [3:0] SM_WORD       = 4'b0100;
    localparam logic [3:0] SM_SIGNED     = 4'b1000;

    // Memory-mapped LED register
    localparam logic [31:0] LED_ADDR = 32'h0000_2000;

    // Command latched for the winning requester
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } mem_cmd_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester and memory-side signals around the arbiter.
// slave = arbiter view, master = requesters + memory view.
`timescale 1ns/1ps
interface dmem_arbiter_if;
    // requester side
    logic        req0, req1;
    logic        we0, we1;
    logic [31:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [3:0]  mask0, mask1;
    logic        ack0, ack1;
    logic        err0, err1;
    logic [31:0] rdata;
    // memory side
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_memread, mem_memwrite;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_rdata;
    logic        mem_stall;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mask0, mask1,
        output ack0, ack1, err0, err1, rdata,
        output mem_addr, mem_wdata, mem_memread, mem_memwrite, mem_sign_mask,
        input  mem_rdata, mem_stall
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mask0, mask1,
        input  ack0, ack1, err0, err1, rdata,
        input  mem_addr, mem_wdata, mem_memread, mem_memwrite, mem_sign_mask,
        output mem_rdata, mem_stall
    );
endinterface

// File: rtl/dmem_arb_select.sv
// Winner selection for the two requesters. sel = 0 picks port 0.
// Default: fixed priority to port 0 with a burst counter that hands the
// port to 1 after MAX_BURST consecutive port-0 grants while 1 waits.
// With DMEM_ARB_ROUND_ROBIN_EN: plain round-robin on a last-grant flag.
`timescale 1ns/1ps
module dmem_arb_select #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req0,
    input  logic req1,
    input  logic grant_en,
    output logic sel
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    // On contention the port not granted last wins
    always_comb begin
        sel = req1;
        if (req0 && req1) sel = ~last_q;
    end

    // Remember who was granted
    always_comb begin
        last_d = last_q;
        if (grant_en) last_d = sel;
    end

    // Starts pointing at port 1 so port 0 wins the first contention
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_q <= 1'b1;
        else          last_q <= last_d;
    end
`else
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

    logic [CNT_W-1:0] burst_q, burst_d;

    // Port 0 wins unless port 1 has waited through a full burst
    always_comb sel = req1 && (!req0 || (burst_q == BURST_LIM));

    // Count port-0 grants only while port 1 is actually waiting
    always_comb begin
        burst_d = burst_q;
        if (!req1)
            burst_d = '0;
        else if (grant_en)
            burst_d = sel ? '0 : burst_q + 1'b1;
    end

    // Burst counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) burst_q <= '0;
        else          burst_q <= burst_d;
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single data-memory port.
// Port 0 = CPU load/store unit, port 1 = debug/DMA loader.
// Each access runs IDLE -> ISSUE -> WAIT -> DONE against the memory's
// stall handshake; DONE gives the winner a one-cycle ack (+err on timeout).
// Optional feature macro: DMEM_ARB_ROUND_ROBIN_EN (round-robin arbitration).
`timescale 1ns/1ps
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    dmem_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e       state_q, state_d;
    logic             win_q, win_d;       // 0 = port 0 owns the access
    mem_cmd_t         cmd_q, cmd_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             grant_en;
    logic             sel;

    // A grant needs an idle sequencer and a memory that is not still busy
    assign grant_en = (state_q == IDLE) && !bus.mem_stall && (bus.req0 || bus.req1);

    dmem_arb_select #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_select (
        .clk      (clk),
        .reset_n  (reset_n),
        .req0     (bus.req0),
        .req1     (bus.req1),
        .grant_en (grant_en),
        .sel      (sel)
    );

    // Next-state and datapath updates of the access sequencer
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cmd_d   = cmd_q;
        tmo_d   = tmo_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (grant_en) begin
                    win_d = sel;
                    err_d = 1'b0;
                    if (sel) begin
                        cmd_d.we    = bus.we1;
                        cmd_d.addr  = bus.addr1;
                        cmd_d.wdata = bus.wdata1;
                        cmd_d.mask  = bus.mask1;
                    end else begin
                        cmd_d.we    = bus.we0;
                        cmd_d.addr  = bus.addr0;
                        cmd_d.wdata = bus.wdata0;
                        cmd_d.mask  = bus.mask0;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                tmo_d = tmo_q + 1'b1;
                // The first WAIT cycle still shows the pre-command stall value
                if ((tmo_q != '0) && !bus.mem_stall) begin
                    rdata_d = bus.mem_rdata;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (tmo_q == TMO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer registers; reset drops any access in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            cmd_q   <= '0;
            tmo_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cmd_q   <= cmd_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode straight from registers so reset clears them at once
    assign bus.ack0          = (state_q == DONE) && !win_q;
    assign bus.ack1          = (state_q == DONE) &&  win_q;
    assign bus.err0          = bus.ack0 && err_q;
    assign bus.err1          = bus.ack1 && err_q;
    assign bus.rdata         = rdata_q;
    assign bus.mem_addr      = cmd_q.addr;
    assign bus.mem_wdata     = cmd_q.wdata;
    assign bus.mem_sign_mask = cmd_q.mask;
    assign bus.mem_memread   = (state_q == ISSUE) && !cmd_q.we;
    assign bus.mem_memwrite  = (state_q == ISSUE) &&  cmd_q.we;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected memory
// commands and acks; monitors pop and compare when the DUT presents them.
`timescale 1ns/1ps
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int TIMEOUT = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    dmem_arbiter_if bus();

    dmem_arbiter #(
        .MAX_BURST (4),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
        bit          chk_rdata;
        int          t_req;
        int          exp_lat;   // cycles counting the sampling cycle; 0 = unchecked
    } ack_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } cmd_exp_t;

    ack_exp_t ack_q[$];
    cmd_exp_t cmd_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int cmd_cnt  = 0;
    bit hang     = 1'b0;

    // Read data the memory model returns per address
    function automatic logic [31:0] rd_model(input logic [31:0] a);
        case (a)
            32'h0000_4004: return 32'hDEAD_BEEF;
            32'h0000_0100: return 32'h1111_1111;
            32'h0000_0200: return 32'h2222_2222;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: stall for one cycle after each command, or forever when hung
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_memread)
            bus.mem_rdata <= rd_model(bus.mem_addr);
        bus.mem_stall <= bus.mem_memread | bus.mem_memwrite | (hang & bus.mem_stall);
    end

    // Monitor: memory commands and acks against the scoreboards
    initial begin
        cmd_exp_t c;
        ack_exp_t a;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.mem_memread || bus.mem_memwrite) begin
                    cmd_cnt++;
                    if (cmd_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_cmd: got rd=%b wr=%b addr=%h expected no command",
                                 bus.mem_memread, bus.mem_memwrite, bus.mem_addr);
                    end else begin
                        c = cmd_q.pop_front();
                        chk("cmd_write", 32'(bus.mem_memwrite), 32'(c.we));
                        chk("cmd_read",  32'(bus.mem_memread),  32'(!c.we));
                        chk("cmd_addr",  bus.mem_addr,  c.addr);
                        chk("cmd_wdata", bus.mem_wdata, c.wdata);
                        chk("cmd_mask",  32'(bus.mem_sign_mask), 32'(c.mask));
                    end
                end
                if (bus.ack0 || bus.ack1) begin
                    chk("ack_overlap", 32'(bus.ack0 & bus.ack1), 32'd0);
                    if (ack_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_ack: got ack0=%b ack1=%b expected none",
                                 bus.ack0, bus.ack1);
                    end else begin
                        a = ack_q.pop_front();
                        chk("ack_port", bus.ack1 ? 32'd1 : 32'd0, 32'(a.port));
                        chk("ack_err", 32'(a.port == 1 ? bus.err1 : bus.err0), 32'(a.err));
                        if (a.chk_rdata) chk("ack_rdata", bus.rdata, a.rdata);
                        if (a.exp_lat > 0) chk("ack_latency", 32'(cyc - a.t_req + 1), 32'(a.exp_lat));
                    end
                end
            end
        end
    end

    task automatic set_req(input int p, input logic r, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata; bus.mask0 = mask;
        end else begin
            bus.req1 = r; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; bus.mask1 = mask;
        end
    endtask

    task automatic push_txn(input int p, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] mask, input logic err,
                            input logic [31:0] rdata, input bit chk_rd, input int lat);
        cmd_exp_t c;
        ack_exp_t a;
        c.we = we; c.addr = addr; c.wdata = wdata; c.mask = mask;
        cmd_q.push_back(c);
        a.port = p; a.err = err; a.rdata = rdata; a.chk_rdata = chk_rd;
        a.t_req = cyc; a.exp_lat = lat;
        ack_q.push_back(a);
    endtask

    // Hold req for n acks (back-to-back requests), then drop it
    task automatic run_port(input int p, input int n, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] mask);
        int got = 0;
        int budget = 0;
        set_req(p, 1'b1, we, addr, wdata, mask);
        while (got < n && budget < 2000) begin
            @(negedge clk);
            budget++;
            if ((p == 0 && bus.ack0) || (p == 1 && bus.ack1)) got++;
        end
        set_req(p, 1'b0, we, addr, wdata, mask);
        if (got < n) begin
            n_checks++; n_fail++;
            $display("FAIL port%0d_ack_wait: got %0d acks expected %0d", p, got, n);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ctl"}, 32'({bus.ack0, bus.ack1, bus.err0, bus.err1,
                                bus.mem_memread, bus.mem_memwrite}), 32'd0);
        chk({tag, "_rdata"}, bus.rdata, 32'd0);
        chk({tag, "_maddr"}, bus.mem_addr, 32'd0);
        chk({tag, "_mwdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_mmask"}, 32'(bus.mem_sign_mask), 32'd0);
    endtask

    initial begin
        int c0;
        int spin;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

        // Reset state
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single read on port 0: ack in the 5th cycle counting the sampling one
        push_txn(0, 1'b0, 32'h4004, 32'd0, SM_WORD, 1'b0, 32'hDEAD_BEEF, 1'b1, 5);
        run_port(0, 1, 1'b0, 32'h4004, 32'd0, SM_WORD);
        repeat (2) @(negedge clk);

        // Write passthrough on port 1
        push_txn(1, 1'b1, 32'h4010, 32'h0000_00A5, 4'b0000, 1'b0, 32'd0, 1'b0, 5);
        run_port(1, 1, 1'b1, 32'h4010, 32'h0000_00A5, 4'b0000);
        repeat (2) @(negedge clk);

        // Timeout on port 1: ISSUE + TIMEOUT WAIT cycles + DONE
        hang = 1'b1;
        push_txn(1, 1'b0, 32'h4020, 32'd0, SM_HALF | SM_SIGNED, 1'b1, 32'd0, 1'b1, 3 + TIMEOUT);
        run_port(1, 1, 1'b0, 32'h4020, 32'd0, SM_HALF | SM_SIGNED);
        hang = 1'b0;
        repeat (3) @(negedge clk);

        // Simultaneous single requests: port 0 then port 1
        push_txn(0, 1'b0, 32'h0100, 32'd0, SM_WORD, 1'b0, 32'h1111_1111, 1'b1, 0);
        push_txn(1, 1'b0, 32'h0200, 32'd0, SM_WORD, 1'b0, 32'h2222_2222, 1'b1, 0);
        fork
            run_port(0, 1, 1'b0, 32'h0100, 32'd0, SM_WORD);
            run_port(1, 1, 1'b0, 32'h0200, 32'd0, SM_WORD);
        join
        repeat (2) @(negedge clk);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
        // Both held for 6 transactions: strict alternation starting at port 0
        for (int i = 0; i < 3; i++) begin
            push_txn(0, 1'b0, 32'h0100, 32'd0, SM_WORD, 1'b0, 32'h1111_1111, 1'b1, 0);
            push_txn(1, 1'b0, 32'h0200, 32'd0, SM_WORD, 1'b0, 32'h2222_2222, 1'b1, 0);
        end
        fork
            run_port(0, 3, 1'b0, 32'h0100, 32'd0, SM_WORD);
            run_port(1, 3, 1'b0, 32'h0200, 32'd0, SM_WORD);
        join
`else
        // Port 0 held for 5, port 1 for 2: grants 0,0,0,0,1,0,1
        for (int i = 0; i < 4; i++)
            push_txn(0, 1'b0, 32'h0100, 32'd0, SM_WORD, 1'b0, 32'h1111_1111, 1'b1, 0);
        push_txn(1, 1'b0, 32'h0200, 32'd0, SM_WORD, 1'b0, 32'h2222_2222, 1'b1, 0);
        push_txn(0, 1'b0, 32'h0100, 32'd0, SM_WORD, 1'b0, 32'h1111_1111, 1'b1, 0);
        push_txn(1, 1'b0, 32'h0200, 32'd0, SM_WORD, 1'b0, 32'h2222_2222, 1'b1, 0);
        fork
            run_port(0, 5, 1'b0, 32'h0100, 32'd0, SM_WORD);
            run_port(1, 2, 1'b0, 32'h0200, 32'd0, SM_WORD);
        join
`endif
        repeat (2) @(negedge clk);

        // Reset asserted in WAIT while memory is stalled: abandoned, no ack
        hang = 1'b1;
        begin
            cmd_exp_t c;
            c.we = 1'b0; c.addr = 32'h4004; c.wdata = 32'd0; c.mask = SM_WORD;
            cmd_q.push_back(c);
        end
        set_req(0, 1'b1, 1'b0, 32'h4004, 32'd0, SM_WORD);
        spin = 0;
        while (!bus.mem_memread && spin < 20) begin
            @(negedge clk);
            spin++;
        end
        if (!bus.mem_memread) begin
            n_checks++; n_fail++;
            $display("FAIL rst_issue_wait: got no ISSUE expected one within 20 cycles");
        end
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_outputs_zero("rst_mid");
        set_req(0, 1'b0, 1'b0, 32'h4004, 32'd0, SM_WORD);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Memory still stalled after reset: request must wait
        push_txn(0, 1'b0, 32'h4004, 32'd0, SM_WORD, 1'b0, 32'hDEAD_BEEF, 1'b1, 0);
        set_req(0, 1'b1, 1'b0, 32'h4004, 32'd0, SM_WORD);
        c0 = cmd_cnt;
        repeat (4) @(negedge clk);
        chk("no_issue_while_stall", 32'(cmd_cnt - c0), 32'd0);
        hang = 1'b0;
        run_port(0, 1, 1'b0, 32'h4004, 32'd0, SM_WORD);
        repeat (3) @(negedge clk);

        chk("ack_sb_drained", 32'(ack_q.size()), 32'd0);
        chk("cmd_sb_drained", 32'(cmd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

endmodule
